// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter + registered bit mux for the 8-to-1 ALU result select; optional hold limit via MUX_ARB_TIMEOUT_EN.
// Latency: req->grant/sel/busy 1 cycle, grant->data_out/data_valid 1 cycle; release hands over with no idle bubble.
// Backpressure: none; req is level-sensitive and the owner keeps the mux until it drops req (or is preempted).
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       data_out,
    output logic       data_valid,
    output logic       preempt
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("mux_rr_arbiter: HOLD_MAX must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] win_idx;
    logic       win_found;
    logic [2:0] cand;
    logic       issue;

    // First set request bit scanning upward from ptr, wrapping mod 8.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic       timeout;

    assign timeout = (state == GRANT) && req[sel] && (hold_cnt == HOLD_LAST);
`endif

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    issue     = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    if (win_found) begin
                        issue = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`ifdef MUX_ARB_TIMEOUT_EN
                // Owner still requests here, so a winner always exists; it is the
                // owner itself only when nobody else is waiting.
                else if (timeout) begin
                    issue = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= 8'h00;
            sel   <= 3'd0;
            ptr   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                grant <= 8'b1 << win_idx;
                sel   <= win_idx;
                ptr   <= win_idx + 3'd1;
            end else if (state_nxt == IDLE) begin
                grant <= 8'h00;
            end
        end
    end

    assign busy = (state == GRANT);

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 8'd0;
            preempt  <= 1'b0;
        end else begin
            preempt <= timeout;
            if (issue) begin
                hold_cnt <= 8'd0;
            end else if (state == GRANT && hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // data_out only samples while a grant is live so it holds when data_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= busy;
            if (busy) begin
                data_out <= data_in[sel];
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (HOLD_MAX=4); timeout expectations follow MUX_ARB_TIMEOUT_EN.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       data_out;
    logic       data_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .sel        (sel),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .preempt    (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({grant, sel, busy, data_out, data_valid, preempt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_initial got grant=%h sel=%0d busy=%b do=%b dv=%b pre=%b want all 0",
                     grant, sel, busy, data_out, data_valid, preempt);
        end
        rst = 1'b0;
        req = 8'hFF;
        data_in = 8'hFF;
        tick();
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant got grant=%h sel=%0d busy=%b want 01 0 1", grant, sel, busy);
        end
        req = 8'hFE;
        tick();
        req = 8'hFF;
        tick();
        checks++;
        if (grant !== 8'h02 || data_out !== 1'b1 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got grant=%h do=%b dv=%b want 02 1 1", grant, data_out, data_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({grant, sel, busy, data_out, data_valid, preempt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_midgrant got grant=%h sel=%0d busy=%b do=%b dv=%b pre=%b want all 0",
                     grant, sel, busy, data_out, data_valid, preempt);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_grant got grant=%h sel=%0d want 01 0", grant, sel);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g;
        for (int k = 1; k <= 8; k++) begin
            req = 8'hFF & ~(8'h01 << ((k - 1) % 8));
            tick();
            exp_g = 8'h01 << (k % 8);
            checks++;
            if (grant !== exp_g || busy !== 1'b1) begin
                errors++;
                $display("FAIL rotation_%0d got grant=%h busy=%b want %h 1", k, grant, busy, exp_g);
            end
            req = 8'hFF;
            tick();
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rotation_hold_%0d got grant=%h want %h", k, grant, exp_g);
            end
        end
    endtask

    task automatic test_wrap();
        req = 8'h40;
        tick();
        checks++;
        if (grant !== 8'h40 || sel !== 3'd6) begin
            errors++;
            $display("FAIL wrap_owner6 got grant=%h sel=%0d want 40 6", grant, sel);
        end
        req = 8'h41;
        tick();
        req = 8'h01;
        tick();
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL wrap_release got grant=%h sel=%0d want 01 0", grant, sel);
        end
        req = 8'h40;
        tick();
        req = 8'h00;
        tick();
        checks++;
        if (grant !== 8'h00 || sel !== 3'd6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle got grant=%h sel=%0d busy=%b want 00 6 0", grant, sel, busy);
        end
        req = 8'h41;
        tick();
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL wrap_from_idle got grant=%h sel=%0d want 01 0", grant, sel);
        end
    endtask

    task automatic test_datapath();
        data_in = 8'h08;
        req = 8'h08;
        tick();
        checks++;
        if (grant !== 8'h08 || sel !== 3'd3) begin
            errors++;
            $display("FAIL data_grant got grant=%h sel=%0d want 08 3", grant, sel);
        end
        tick();
        checks++;
        if (data_out !== 1'b1 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL data_first got do=%b dv=%b want 1 1", data_out, data_valid);
        end
        data_in = 8'h00;
        #1;
        checks++;
        if (data_out !== 1'b1) begin
            errors++;
            $display("FAIL data_lag got do=%b want 1", data_out);
        end
        tick();
        checks++;
        if (data_out !== 1'b0) begin
            errors++;
            $display("FAIL data_toggle got do=%b want 0", data_out);
        end
        data_in = 8'hF7;
        tick();
        checks++;
        if (data_out !== 1'b0 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL data_other_bits got do=%b dv=%b want 0 1", data_out, data_valid);
        end
        data_in = 8'h08;
        tick();
        checks++;
        if (data_out !== 1'b1) begin
            errors++;
            $display("FAIL data_back got do=%b want 1", data_out);
        end
    endtask

    task automatic test_idle();
        req = 8'h00;
        tick();
        checks++;
        if (busy !== 1'b0 || grant !== 8'h00 || sel !== 3'd3 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_edge got busy=%b grant=%h sel=%0d dv=%b want 0 00 3 1",
                     busy, grant, sel, data_valid);
        end
        data_in = 8'h00;
        tick();
        checks++;
        if (data_valid !== 1'b0 || sel !== 3'd3 || data_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_valid got dv=%b sel=%0d do=%b want 0 3 1", data_valid, sel, data_out);
        end
        tick();
        checks++;
        if (data_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got do=%b busy=%b want 1 0", data_out, busy);
        end
    endtask

    task automatic test_timeout();
        req = 8'h06;
        tick();
        checks++;
        if (grant !== 8'h02 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL to_grant got grant=%h pre=%b want 02 0", grant, preempt);
        end
`ifdef MUX_ARB_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (grant !== 8'h02 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL to_hold_%0d got grant=%h pre=%b want 02 0", k, grant, preempt);
            end
        end
        tick();
        checks++;
        if (grant !== 8'h04 || preempt !== 1'b1) begin
            errors++;
            $display("FAIL to_preempt got grant=%h pre=%b want 04 1", grant, preempt);
        end
        tick();
        checks++;
        if (grant !== 8'h04 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_end got grant=%h pre=%b want 04 0", grant, preempt);
        end
        req = 8'h02;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (grant !== 8'h02 || preempt !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL to_solo_%0d got grant=%h pre=%b want 02 %0d", k, grant, preempt, (k % 4 == 0));
            end
        end
`else
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (grant !== 8'h02 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL no_to_hold_%0d got grant=%h pre=%b want 02 0", k, grant, preempt);
            end
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        data_in = 8'h00;
        tick();
        test_reset();
        test_rotation();
        test_wrap();
        test_datapath();
        test_idle();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
